// File: rtl/sid_link_pkg.sv
// ============================================================================
// sid_link_pkg
// Shared definitions for the SID register-write serial link: bit-period
// derivation, link header bit positions, write-entry type and byte encoders.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package sid_link_pkg;

  // Link header layout of byte0: {1, addr[4:0], data[7:6]}
  localparam int HDR_BIT  = 7;
  localparam int ADDR_MSB = 6;
  localparam int ADDR_LSB = 2;

  // One buffered register write
  typedef struct packed {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_entry_t;

  // Transmit sequencing states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_HI = 2'd1,
    SEND_LO = 2'd2
  } link_state_t;

  // Clock cycles per UART bit
  function automatic int calc_clk_div(input int clk_rate, input int baud);
    return clk_rate / baud;
  endfunction

  // First link byte: header flag, address, top two data bits
  function automatic logic [7:0] enc_hi(input wr_entry_t e);
    logic [7:0] b;
    b                    = '0;
    b[HDR_BIT]           = 1'b1;
    b[ADDR_MSB:ADDR_LSB] = e.addr;
    b[1:0]               = e.data[7:6];
    return b;
  endfunction

  // Second link byte: low six data bits, header flag and bit 6 held low
  function automatic logic [7:0] enc_lo(input wr_entry_t e);
    return {2'b00, e.data[5:0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// uart_tx
// 8N1 byte serialiser. Accepts a byte over valid/ready and shifts it out LSB
// first. Ready is also raised in the final cycle of the stop bit so that a
// following byte starts with no idle gap.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx #(
  parameter int CLK_DIV = 375
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic [7:0] byte_data,
  output logic       tx
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_idx;   // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]       shreg;
  logic             busy;
  logic             bit_end;
  logic             frame_end;

  // Bit boundary and end-of-frame detection
  assign bit_end    = (baud_cnt == '0);
  assign frame_end  = busy && bit_end && (bit_idx == 4'd9);
  assign byte_ready = !busy || frame_end;

  // Baud counter, bit index, shift register and registered line output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else if (byte_valid && byte_ready) begin
      busy     <= 1'b1;
      baud_cnt <= CNT_RELOAD;
      bit_idx  <= '0;
      shreg    <= byte_data;
      tx       <= 1'b0;
    end else if (busy) begin
      if (!bit_end) begin
        baud_cnt <= baud_cnt - 1'b1;
      end else if (bit_idx == 4'd9) begin
        busy <= 1'b0;
      end else begin
        bit_idx  <= bit_idx + 1'b1;
        baud_cnt <= CNT_RELOAD;
        if (bit_idx == 4'd8) begin
          tx <= 1'b1;
        end else begin
          tx    <= shreg[0];
          shreg <= {1'b0, shreg[7:1]};
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sid_link_tx.sv
// ============================================================================
// sid_link_tx
// Host-side SID link transmitter: buffers (addr, data) writes in a FIFO,
// encodes each into two link bytes and sends them back to back as 8N1 UART.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sid_link_tx
  import sid_link_pkg::*;
#(
  parameter int CLK_RATE   = 48000000,
  parameter int BAUD       = 128000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        WR_VALID,
  output logic                        WR_READY,
  input  logic [4:0]                  WR_ADDR,
  input  logic [7:0]                  WR_DATA,
  output logic                        TX,
  output logic                        BUSY,
  output logic [$clog2(FIFO_DEPTH):0] LEVEL
);

  localparam int CLK_DIV = calc_clk_div(CLK_RATE, BAUD);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);

  wr_entry_t   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   level;
  logic          push;
  logic          pop;
  logic          empty;
  wr_entry_t     head;
  wr_entry_t     cur;

  link_state_t   state;
  link_state_t   state_nxt;
  logic          byte_valid;
  logic          byte_ready;
  logic [7:0]    byte_data;

  assign empty    = (level == '0);
  assign WR_READY = (level != FULL_LEVEL);
  assign push     = WR_VALID && WR_READY;
  assign head     = mem[rptr];
  assign LEVEL    = level;
  assign BUSY     = (state != IDLE) || !empty;

  // FIFO storage; contents need no reset since level gates every read
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wptr] <= wr_entry_t'({WR_ADDR, WR_DATA});
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave level as is
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // State register, plus a copy of the popped entry for the second byte
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cur   <= '0;
    end else begin
      state <= state_nxt;
      if (pop) cur <= head;
    end
  end

  // Next-state: advance whenever the serialiser takes the next byte
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty && byte_ready) state_nxt = SEND_HI;
      SEND_HI: if (byte_ready)           state_nxt = SEND_LO;
      SEND_LO: if (byte_ready)           state_nxt = empty ? IDLE : SEND_HI;
      default:                           state_nxt = IDLE;
    endcase
  end

  // Outputs: byte offered to the serialiser and FIFO pop strobe
  always_comb begin
    byte_valid = 1'b0;
    byte_data  = enc_hi(head);
    pop        = 1'b0;
    case (state)
      IDLE, SEND_LO: begin
        byte_valid = !empty;
        pop        = !empty && byte_ready;
      end
      SEND_HI: begin
        byte_valid = 1'b1;
        byte_data  = enc_lo(cur);
      end
      default: ;
    endcase
  end

  uart_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_uart_tx (
    .clk        (CLK),
    .rst        (RST),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .tx         (TX)
  );

endmodule

`default_nettype wire

// File: tb/tb_sid_link_tx.sv
// ============================================================================
// tb_sid_link_tx
// Self-checking bench for sid_link_tx: a driver pushes expected writes into a
// scoreboard; an independent line receiver decodes TX and checks each write.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sid_link_tx;

  localparam int CLK_RATE = 48000000;
  localparam int BAUD     = 3000000;
  localparam int DEPTH    = 8;
  localparam int DIV      = CLK_RATE / BAUD;   // 16 cycles per bit
  localparam int T        = 10;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       WR_VALID = 1'b0;
  logic [4:0] WR_ADDR = '0;
  logic [7:0] WR_DATA = '0;
  logic       WR_READY;
  logic       TX;
  logic       BUSY;
  logic [3:0] LEVEL;

  always #(T/2) CLK = ~CLK;

  sid_link_tx #(
    .CLK_RATE   (CLK_RATE),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .WR_VALID (WR_VALID),
    .WR_READY (WR_READY),
    .WR_ADDR  (WR_ADDR),
    .WR_DATA  (WR_DATA),
    .TX       (TX),
    .BUSY     (BUSY),
    .LEVEL    (LEVEL)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];
  time starts[$];
  time accept_time;
  time last_b0_start;
  int  n_rx = 0;
  bit  burst_mode = 0;
  bit  saw_full = 0;

  // ---------------- line receiver / scoreboard monitor ----------------
  bit   mon_active = 0;
  int   nb, k, cur_byte, b0;
  int   byte_idx = 0;
  time  byte_start, b0_start;
  logic prev_tx = 1'b1;
  wr_t  e;

  always @(negedge CLK) begin
    if (RST) begin
      mon_active = 0;
      byte_idx   = 0;
      prev_tx    = 1'b1;
    end else begin
      if (!mon_active) begin
        if (TX == 1'b0) begin
          mon_active = 1;
          nb = 0; k = 0; cur_byte = 0;
          byte_start = $time - T/2;
        end
      end else begin
        nb++;
        if (TX !== prev_tx) chk("bit_edge_alignment", nb % DIV, 0);
      end
      if (mon_active && nb == DIV/2 + k*DIV) begin
        if (k == 0) chk("start_bit", int'(TX), 0);
        else if (k <= 8) cur_byte |= (TX ? 1 : 0) << (k-1);
        else begin
          chk("stop_bit", int'(TX), 1);
          mon_active = 0;
          if (byte_idx == 0) begin
            b0 = cur_byte; b0_start = byte_start; byte_idx = 1;
          end else begin
            byte_idx = 0;
            chk("byte_gap_cycles", int'((byte_start - b0_start) / T), 10*DIV);
            chk("byte1_bit6", (cur_byte >> 6) & 1, 0);
            if (exp_q.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL unexpected_write: got b0=%02h b1=%02h, expected none", b0, cur_byte);
            end else begin
              e = exp_q.pop_front();
              chk("byte0", b0, 128 + e.addr*4 + e.data/64);
              chk("byte1", cur_byte, e.data % 64);
              last_b0_start = b0_start;
              starts.push_back(b0_start);
              n_rx++;
            end
          end
        end
        k++;
      end
      if (burst_mode) begin
        chk("ready_vs_level", int'(WR_READY), (LEVEL != DEPTH) ? 1 : 0);
        if (LEVEL == DEPTH) saw_full = 1;
      end
      prev_tx = TX;
    end
  end

  // ---------------- driver ----------------
  task automatic do_write(input int a, input int d);
    bit r;
    int n;
    n = 0;
    @(negedge CLK);
    WR_VALID = 1'b1; WR_ADDR = 5'(a); WR_DATA = 8'(d);
    r = WR_READY;
    @(posedge CLK);
    while (!r && n < 20000) begin
      @(negedge CLK); r = WR_READY;
      @(posedge CLK); n++;
    end
    if (r) begin
      exp_q.push_back('{a, d});
      accept_time = $time;
    end else begin
      n_checks++; n_fail++;
      $display("FAIL write_accept_timeout: WR_READY stayed 0, required 1");
    end
  endtask

  task automatic idle_bus();
    @(negedge CLK);
    WR_VALID = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge CLK);
      if (!BUSY && !mon_active && byte_idx == 0) begin ok = 1; break; end
    end
    chk("drain_done", int'(ok), 1);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  int rx0;

  initial begin
    // Reset values
    #1 RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("reset_tx", int'(TX), 1);
    chk("reset_ready", int'(WR_READY), 1);
    chk("reset_busy", int'(BUSY), 0);
    chk("reset_level", int'(LEVEL), 0);
    @(negedge CLK) RST = 1'b0;
    repeat (2) @(negedge CLK);

    // 1: single write encoding and first-word latency
    rx0 = n_rx;
    do_write(5'h18, 8'hA5);
    idle_bus();
    chk("t1_level_after_accept", int'(LEVEL), 1);
    chk("t1_tx_still_idle", int'(TX), 1);
    @(negedge CLK);
    chk("t1_level_after_pop", int'(LEVEL), 0);
    chk("t1_tx_start", int'(TX), 0);
    wait_drain();
    chk("t1_latency_cycles", int'((last_b0_start - accept_time) / T), 1);
    chk("t1_rx_count", n_rx - rx0, 1);

    // 2: extreme values
    rx0 = n_rx;
    do_write(5'h1F, 8'h00);
    idle_bus();
    wait_drain();
    chk("t2_rx_count", n_rx - rx0, 1);

    // 3: single loopback write
    rx0 = n_rx;
    do_write(5'h04, 8'h11);
    idle_bus();
    wait_drain();
    chk("t3_rx_count", n_rx - rx0, 1);

    // 4: back-pressure burst, no line gaps
    rx0 = n_rx;
    starts.delete();
    saw_full = 0;
    burst_mode = 1;
    for (int i = 0; i < 10; i++) do_write(i, 8'h40 + i);
    idle_bus();
    wait_drain();
    burst_mode = 0;
    chk("t4_saw_full", int'(saw_full), 1);
    chk("t4_rx_count", n_rx - rx0, 10);
    if (starts.size() == 10)
      chk("t4_total_line_cycles", int'((starts[9] - starts[0]) / T) + 20*DIV, 200*DIV);
    else
      chk("t4_start_records", starts.size(), 10);

    // 5: reset during bit 4 of byte0
    rx0 = n_rx;
    do_write(5'h09, 8'h33);
    idle_bus();
    repeat (4*DIV + DIV/2) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("t5_tx_async", int'(TX), 1);
    chk("t5_level", int'(LEVEL), 0);
    chk("t5_busy", int'(BUSY), 0);
    exp_q.delete();
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    do_write(5'h02, 8'h7F);
    idle_bus();
    wait_drain();
    chk("t5_rx_count", n_rx - rx0, 1);

    // 6: push on the pop edge
    rx0 = n_rx;
    do_write(5'h0A, 8'hC3);
    #1 chk("t6_level_first", int'(LEVEL), 1);
    do_write(5'h15, 8'h3C);
    #1 chk("t6_level_push_pop", int'(LEVEL), 1);
    idle_bus();
    wait_drain();
    chk("t6_rx_count", n_rx - rx0, 2);

    // 7: randomized writes with random gaps
    rx0 = n_rx;
    for (int i = 0; i < 24; i++) begin
      do_write($urandom_range(0, 31), $urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        idle_bus();
        repeat ($urandom_range(0, 3*DIV)) @(negedge CLK);
      end
    end
    idle_bus();
    wait_drain();
    chk("t7_rx_count", n_rx - rx0, 24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
